// File: rtl/set_assoc_cache.sv
`default_nettype none
// ============================================================================
// Module   : set_assoc_cache
// Purpose  : Two-way set-associative, read-only, blocking cache with
//            per-set LRU replacement, whole-line refill and flush.
// Ports    : clk, rst            - clock, asynchronous active-high reset
//            cpu_req/cpu_addr    - read request (taken when cpu_ready=1)
//            flush               - invalidate all lines (taken when cpu_ready=1)
//            cpu_ready           - cache idle and able to take a command
//            cpu_valid/cpu_data  - one-cycle read response / held read word
//            hit                 - response came from the cache (1) or refill (0)
//            mem_req/mem_addr    - line refill request, line-aligned address
//            mem_ack/mem_data    - refill response carrying a full line
//            hit_cnt/miss_cnt    - saturating 16-bit access counters
// Revision : 1.0 - initial release
// ============================================================================
module set_assoc_cache #(
  parameter int   ADDR_W   = 32,
  parameter int   WORD_W   = 32,
  parameter int   INDEX_W  = 8,
  parameter int   OFFSET_W = 4,
  localparam int  TAG_W    = ADDR_W - INDEX_W - OFFSET_W,
  localparam int  LINE_W   = WORD_W * (2 ** OFFSET_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              flush,
  output logic              cpu_ready,
  output logic              cpu_valid,
  output logic [WORD_W-1:0] cpu_data,
  output logic              hit,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [LINE_W-1:0] mem_data,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt
);

  localparam int SETS = 2 ** INDEX_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    REFILL  = 2'd2,
    FLUSH   = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Tag and line storage carry no reset: the valid bits alone decide
  // whether their contents mean anything.
  logic [TAG_W-1:0]     tag_q  [SETS][2];
  logic [LINE_W-1:0]    line_q [SETS][2];
  logic [SETS-1:0][1:0] valid_q;
  logic [SETS-1:0]      lru_q;

  logic [ADDR_W-1:0]    addr_q;
  logic                 cpu_valid_q;
  logic                 hit_q;
  logic [WORD_W-1:0]    cpu_data_q;
  logic [ADDR_W-1:0]    mem_addr_q;
  logic [15:0]          hit_cnt_q;
  logic [15:0]          miss_cnt_q;

  logic [TAG_W-1:0]     req_tag;
  logic [INDEX_W-1:0]   req_idx;
  logic [OFFSET_W-1:0]  req_off;
  logic [1:0]           way_match;
  logic                 lookup_hit;
  logic                 hit_way;
  logic                 victim;
  logic [LINE_W-1:0]    hit_line;
  logic [31:0]          word_lsb;

  assign req_tag = addr_q[ADDR_W-1:INDEX_W+OFFSET_W];
  assign req_idx = addr_q[INDEX_W+OFFSET_W-1:OFFSET_W];
  assign req_off = addr_q[OFFSET_W-1:0];

  assign way_match[0] = valid_q[req_idx][0] && (tag_q[req_idx][0] == req_tag);
  assign way_match[1] = valid_q[req_idx][1] && (tag_q[req_idx][1] == req_tag);
  assign lookup_hit   = |way_match;
  // A line is only ever filled on a miss, so at most one way can match.
  assign hit_way      = way_match[1];
  assign hit_line     = line_q[req_idx][hit_way];
  assign word_lsb     = 32'(req_off) * 32'(WORD_W);

  // Fill an empty way first (way 0 preferred); otherwise evict the LRU way.
  assign victim = !valid_q[req_idx][0] ? 1'b0 :
                  !valid_q[req_idx][1] ? 1'b1 : lru_q[req_idx];

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (flush) begin
          state_d = FLUSH;
        end else if (cpu_req) begin
          state_d = COMPARE;
        end
      end
      COMPARE: state_d = lookup_hit ? IDLE : REFILL;
      REFILL:  if (mem_ack) state_d = IDLE;
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath, status bits and counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= '0;
      lru_q       <= '0;
      addr_q      <= '0;
      cpu_valid_q <= 1'b0;
      hit_q       <= 1'b0;
      cpu_data_q  <= '0;
      mem_addr_q  <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      cpu_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!flush && cpu_req) begin
            addr_q <= cpu_addr;
          end
        end
        COMPARE: begin
          if (lookup_hit) begin
            cpu_data_q      <= hit_line[word_lsb +: WORD_W];
            cpu_valid_q     <= 1'b1;
            hit_q           <= 1'b1;
            lru_q[req_idx]  <= ~hit_way;
            if (hit_cnt_q != 16'hFFFF) begin
              hit_cnt_q <= hit_cnt_q + 16'd1;
            end
          end else begin
            mem_addr_q <= {req_tag, req_idx, {OFFSET_W{1'b0}}};
            if (miss_cnt_q != 16'hFFFF) begin
              miss_cnt_q <= miss_cnt_q + 16'd1;
            end
          end
        end
        REFILL: begin
          if (mem_ack) begin
            valid_q[req_idx][victim] <= 1'b1;
            lru_q[req_idx]           <= ~victim;
            cpu_data_q               <= mem_data[word_lsb +: WORD_W];
            cpu_valid_q              <= 1'b1;
            hit_q                    <= 1'b0;
          end
        end
        FLUSH: begin
          valid_q <= '0;
          lru_q   <= '0;
        end
        default: ;
      endcase
    end
  end

  // Line and tag arrays; under reset the FSM sits in IDLE so no write occurs.
  always_ff @(posedge clk) begin
    if ((state_q == REFILL) && mem_ack) begin
      tag_q[req_idx][victim]  <= req_tag;
      line_q[req_idx][victim] <= mem_data;
    end
  end

  assign cpu_ready = (state_q == IDLE);
  assign mem_req   = (state_q == REFILL);
  assign mem_addr  = mem_addr_q;
  assign cpu_valid = cpu_valid_q;
  assign cpu_data  = cpu_data_q;
  assign hit       = hit_q;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_set_assoc_cache.sv
`default_nettype none
// ============================================================================
// Module   : tb_set_assoc_cache
// Purpose  : Directed self-checking bench for set_assoc_cache (default
//            parameters: 32-bit addresses, 256 sets, 16 words per line).
// Revision : 1.0 - initial release
// ============================================================================
module tb_set_assoc_cache;

  logic         clk = 1'b0;
  logic         rst;
  logic         cpu_req;
  logic [31:0]  cpu_addr;
  logic         flush;
  logic         cpu_ready;
  logic         cpu_valid;
  logic [31:0]  cpu_data;
  logic         hit;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ack;
  logic [511:0] mem_data;
  logic [15:0]  hit_cnt;
  logic [15:0]  miss_cnt;

  int checks   = 0;
  int errors   = 0;
  int exp_hits = 0;
  int exp_miss = 0;

  set_assoc_cache dut (
    .clk      (clk),
    .rst      (rst),
    .cpu_req  (cpu_req),
    .cpu_addr (cpu_addr),
    .flush    (flush),
    .cpu_ready(cpu_ready),
    .cpu_valid(cpu_valid),
    .cpu_data (cpu_data),
    .hit      (hit),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_ack  (mem_ack),
    .mem_data (mem_data),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Line whose word k holds base+k.
  function automatic logic [511:0] mk_line(input logic [31:0] base);
    logic [511:0] l;
    l = '0;
    for (int k = 0; k < 16; k++) begin
      l[32*k +: 32] = base + 32'(k);
    end
    return l;
  endfunction

  // One-cycle request; returns at the negedge after the sampling edge.
  task automatic req(input logic [31:0] a);
    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_addr = a;
    @(negedge clk);
    cpu_req  = 1'b0;
  endtask

  task automatic read_hit(input logic [31:0] a, input logic [31:0] d);
    req(a);
    check("cmp_valid0", cpu_valid, 32'd0);
    @(negedge clk);
    if (exp_hits < 65535) exp_hits++;
    check("hit_valid", cpu_valid, 32'd1);
    check("hit_flag", hit, 32'd1);
    check("hit_data", cpu_data, d);
    check("hit_memreq", mem_req, 32'd0);
    check("hit_cnt", hit_cnt, exp_hits);
  endtask

  task automatic read_miss(input logic [31:0] a, input logic [511:0] line, input logic [31:0] d);
    logic [31:0] la;
    la = a & 32'hFFFF_FFF0;
    req(a);
    check("cmp_valid0", cpu_valid, 32'd0);
    @(negedge clk);
    if (exp_miss < 65535) exp_miss++;
    check("miss_memreq", mem_req, 32'd1);
    check("miss_memaddr", mem_addr, la);
    check("miss_valid0", cpu_valid, 32'd0);
    check("miss_ready0", cpu_ready, 32'd0);
    check("miss_cnt", miss_cnt, exp_miss);
    @(negedge clk);
    check("miss_memreq_hold", mem_req, 32'd1);
    check("miss_memaddr_hold", mem_addr, la);
    mem_ack  = 1'b1;
    mem_data = line;
    @(negedge clk);
    mem_ack  = 1'b0;
    mem_data = '0;
    check("fill_valid", cpu_valid, 32'd1);
    check("fill_hit0", hit, 32'd0);
    check("fill_data", cpu_data, d);
    check("fill_memreq0", mem_req, 32'd0);
  endtask

  initial begin
    rst      = 1'b1;
    cpu_req  = 1'b0;
    cpu_addr = '0;
    flush    = 1'b0;
    mem_ack  = 1'b0;
    mem_data = '0;

    // Reset state
    #2;
    check("rst_valid", cpu_valid, 32'd0);
    check("rst_hit", hit, 32'd0);
    check("rst_data", cpu_data, 32'd0);
    check("rst_memreq", mem_req, 32'd0);
    check("rst_memaddr", mem_addr, 32'd0);
    check("rst_hitcnt", hit_cnt, 32'd0);
    check("rst_misscnt", miss_cnt, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("idle_ready", cpu_ready, 32'd1);

    // Cold miss then repeat hit in the same line
    read_miss(32'h0000_1234, mk_line(32'h0), 32'd4);
    read_hit(32'h0000_1237, 32'd7);

    // Two lines in set 0x23, then LRU-driven eviction
    read_miss(32'h0001_1230, mk_line(32'h100), 32'h100);
    read_hit(32'h0000_1230, 32'h0);
    read_miss(32'h0002_1230, mk_line(32'h200), 32'h200);
    read_hit(32'h0000_1230, 32'h0);
    read_hit(32'h0002_1234, 32'h204);
    read_miss(32'h0001_1230, mk_line(32'h100), 32'h100);
    read_hit(32'h0002_1230, 32'h200);
    read_miss(32'h0000_1230, mk_line(32'h0), 32'h0);

    // Stray mem_ack while idle must not disturb anything
    @(negedge clk);
    mem_ack  = 1'b1;
    mem_data = mk_line(32'hDEAD_0000);
    @(negedge clk);
    mem_ack  = 1'b0;
    mem_data = '0;
    check("stray_ack_valid", cpu_valid, 32'd0);
    check("stray_ack_data", cpu_data, 32'h0);
    read_hit(32'h0000_1235, 32'd5);

    // Flush wins over a simultaneous request; the request is dropped
    @(negedge clk);
    flush    = 1'b1;
    cpu_req  = 1'b1;
    cpu_addr = 32'h0000_1230;
    @(negedge clk);
    flush    = 1'b0;
    cpu_req  = 1'b0;
    check("flush_busy", cpu_ready, 32'd0);
    check("flush_memreq", mem_req, 32'd0);
    @(negedge clk);
    check("flush_done", cpu_ready, 32'd1);
    check("flush_novalid", cpu_valid, 32'd0);
    check("flush_hitcnt", hit_cnt, exp_hits);
    read_miss(32'h0000_1230, mk_line(32'h300), 32'h300);

    // Reset in the middle of a refill, then a late mem_ack
    req(32'h0000_5670);
    @(negedge clk);
    check("pre_rst_memreq", mem_req, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_memreq", mem_req, 32'd0);
    check("rst_mid_valid", cpu_valid, 32'd0);
    check("rst_mid_hitcnt", hit_cnt, 32'd0);
    check("rst_mid_misscnt", miss_cnt, 32'd0);
    exp_hits = 0;
    exp_miss = 0;
    @(negedge clk);
    rst      = 1'b0;
    mem_ack  = 1'b1;
    mem_data = mk_line(32'h500);
    @(negedge clk);
    mem_ack  = 1'b0;
    mem_data = '0;
    check("late_ack_valid", cpu_valid, 32'd0);
    check("late_ack_memreq", mem_req, 32'd0);
    read_miss(32'h0000_5670, mk_line(32'h600), 32'h600);
    read_miss(32'h0000_1234, mk_line(32'h0), 32'd4);

    // Hit counter saturation: start near the top, then keep hitting
    @(negedge clk);
    force dut.hit_cnt_q = 16'hFFF0;
    #1;
    release dut.hit_cnt_q;
    exp_hits = 32'hFFF0;
    for (int i = 0; i < 20; i++) begin
      req(32'h0000_1234);
      @(negedge clk);
    end
    check("sat_hitcnt", hit_cnt, 32'hFFFF);
    exp_hits = 65535;
    read_hit(32'h0000_1239, 32'd9);
    check("sat_misscnt", miss_cnt, exp_miss);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
